transport_rx: RTL and testbench

- Receive end of the 8-bit switch-code transport link.
- Samples the parallel `data` word driven by the transport sender, checks its framing, and qualifies it for stability.
- On acceptance, decodes each new 3-bit switch code into a binary code, a one-hot vector and a single-cycle valid strobe.
- Keeps a sticky framing-error flag and a saturating count of accepted codes for status and debug.

---
 rtl/transport_rx.sv | 88 ++++++++
 tb/tb_transport_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/transport_rx.sv
// Receive end of the 8-bit switch-code link: framing check, stability qualification,
// and decode of each newly accepted 3-bit code into binary, one-hot and a valid strobe.
module transport_rx #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             err_clr,
    output logic [2:0]       code_out,
    output logic [7:0]       onehot_out,
    output logic             code_valid,
    output logic             frame_err,
    output logic [CNT_W-1:0] rx_count
);

    typedef enum logic [1:0] {IDLE, QUAL, BAD} state_t;

    localparam logic [7:0] ACC_CNT = 8'(STABLE_CYCLES - 1);

    state_t     state;
    logic [7:0] s_q;
    logic [7:0] last_word;
    logic [7:0] cand;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            s_q        <= '0;
            last_word  <= '0;
            cand       <= '0;
            cnt        <= '0;
            code_out   <= '0;
            onehot_out <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_count   <= '0;
        end else begin
            s_q        <= data_in;
            code_valid <= 1'b0;
            // Clear first so a same-cycle framing error below takes priority.
            if (err_clr)
                frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (s_q != last_word) begin
                        if (s_q[7:3] != 5'b0) begin
                            frame_err <= 1'b1;
                            cand      <= s_q;
                            state     <= BAD;
                        end else if (s_q == 8'h00) begin
                            last_word <= '0;
                        end else begin
                            cand  <= s_q;
                            cnt   <= 8'd1;
                            state <= QUAL;
                        end
                    end
                end
                QUAL: begin
                    if (s_q != cand) begin
                        state <= IDLE;
                    end else if (cnt < ACC_CNT) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        code_out   <= cand[2:0];
                        onehot_out <= 8'(1) << cand[2:0];
                        code_valid <= 1'b1;
                        last_word  <= cand;
                        if (rx_count != '1)
                            rx_count <= rx_count + CNT_W'(1);
                        state <= IDLE;
                    end
                end
                BAD: begin
                    // Held bad word is flagged only once, on entry from IDLE.
                    if (s_q != cand)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transport_rx.sv
// Bench for transport_rx: directed table, hand-written reset/latency corners,
// randomized segments against a segment-level model, and counter saturation at CNT_W=2.
module tb_transport_rx;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       err_clr;
    logic [2:0] code_out;
    logic [7:0] onehot_out;
    logic       code_valid;
    logic       frame_err;
    logic [7:0] rx_count;

    logic       rst2;
    logic [7:0] data2;
    logic       err_clr2;
    logic [2:0] code_out2;
    logic [7:0] onehot_out2;
    logic       code_valid2;
    logic       frame_err2;
    logic [1:0] rx_count2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    transport_rx #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .err_clr(err_clr),
        .code_out(code_out), .onehot_out(onehot_out), .code_valid(code_valid),
        .frame_err(frame_err), .rx_count(rx_count)
    );

    transport_rx #(.STABLE_CYCLES(SC), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .data_in(data2), .err_clr(err_clr2),
        .code_out(code_out2), .onehot_out(onehot_out2), .code_valid(code_valid2),
        .frame_err(frame_err2), .rx_count(rx_count2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] data;
        logic       clr;
        int         n;
        int         pulses;
        logic [2:0] code;
        logic [7:0] oh;
        logic       ferr;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    // Randomized segment stimulus and expected per-evaluation events.
    logic [7:0] d[$];
    bit         evv[$];
    bit         evb[$];

    initial begin
        int         pulses;
        int         lost;
        int         prev;
        int         s, f, len;
        logic [7:0] w;
        logic [7:0] mlast;
        logic [2:0] mcode;
        logic [7:0] mcnt;
        logic       mferr;
        int         codes2[5];

        rst = 1'b0; data_in = 8'h05; err_clr = 1'b0;
        rst2 = 1'b0; data2 = 8'h00; err_clr2 = 1'b0;

        // Reset held with a valid word present, then exact acceptance latency.
        repeat (3) tick();
        chk("reset code_out", int'(code_out), 0);
        chk("reset onehot", int'(onehot_out), 0);
        chk("reset valid", int'(code_valid), 0);
        chk("reset frame_err", int'(frame_err), 0);
        chk("reset rx_count", int'(rx_count), 0);
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("latency valid k=%0d", k), int'(code_valid), (k == 5) ? 1 : 0);
        end
        chk("latency code_out", int'(code_out), 5);
        chk("latency onehot", int'(onehot_out), 8'h20);
        chk("latency rx_count", int'(rx_count), 1);

        // Reset in the middle of qualification aborts it, then requalifies.
        rst = 1'b0; data_in = 8'h00;
        repeat (2) tick();
        rst = 1'b1; data_in = 8'h06;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("midqual valid", int'(code_valid), 0);
        chk("midqual rx_count", int'(rx_count), 0);
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("requal valid k=%0d", k), int'(code_valid), (k == 5) ? 1 : 0);
        end
        chk("requal code_out", int'(code_out), 6);
        chk("requal rx_count", int'(rx_count), 1);

        // Directed table: {rst, data, err_clr, cycles, pulses, code, onehot, ferr, count}.
        tbl.push_back('{1'b0, 8'h05, 1'b0, 3,  0, 3'd0, 8'h00, 1'b0, 8'd0});
        tbl.push_back('{1'b1, 8'h05, 1'b0, 8,  1, 3'd5, 8'h20, 1'b0, 8'd1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 2,  0, 3'd0, 8'h00, 1'b0, 8'd0});
        tbl.push_back('{1'b1, 8'h03, 1'b0, 10, 1, 3'd3, 8'h08, 1'b0, 8'd1});
        tbl.push_back('{1'b1, 8'h07, 1'b0, 10, 1, 3'd7, 8'h80, 1'b0, 8'd2});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 2,  0, 3'd0, 8'h00, 1'b0, 8'd0});
        tbl.push_back('{1'b1, 8'h02, 1'b0, 8,  1, 3'd2, 8'h04, 1'b0, 8'd1});
        tbl.push_back('{1'b1, 8'h06, 1'b0, 2,  0, 3'd2, 8'h04, 1'b0, 8'd1});
        tbl.push_back('{1'b1, 8'h02, 1'b0, 8,  0, 3'd2, 8'h04, 1'b0, 8'd1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 2,  0, 3'd0, 8'h00, 1'b0, 8'd0});
        tbl.push_back('{1'b1, 8'h04, 1'b0, 8,  1, 3'd4, 8'h10, 1'b0, 8'd1});
        tbl.push_back('{1'b1, 8'h00, 1'b0, 3,  0, 3'd4, 8'h10, 1'b0, 8'd1});
        tbl.push_back('{1'b1, 8'h04, 1'b0, 8,  1, 3'd4, 8'h10, 1'b0, 8'd2});
        tbl.push_back('{1'b1, 8'h1A, 1'b0, 6,  0, 3'd4, 8'h10, 1'b1, 8'd2});
        tbl.push_back('{1'b1, 8'h1A, 1'b1, 1,  0, 3'd4, 8'h10, 1'b0, 8'd2});
        tbl.push_back('{1'b1, 8'h1A, 1'b0, 4,  0, 3'd4, 8'h10, 1'b0, 8'd2});
        tbl.push_back('{1'b1, 8'h81, 1'b0, 2,  0, 3'd4, 8'h10, 1'b0, 8'd2});
        tbl.push_back('{1'b1, 8'h81, 1'b1, 1,  0, 3'd4, 8'h10, 1'b1, 8'd2});
        tbl.push_back('{1'b1, 8'h81, 1'b0, 3,  0, 3'd4, 8'h10, 1'b1, 8'd2});

        foreach (tbl[r]) begin
            rst = tbl[r].rst; data_in = tbl[r].data; err_clr = tbl[r].clr;
            pulses = 0;
            for (int k = 0; k < tbl[r].n; k++) begin
                tick();
                if (code_valid) pulses++;
            end
            chk($sformatf("row%0d pulses", r), pulses, tbl[r].pulses);
            chk($sformatf("row%0d code_out", r), int'(code_out), int'(tbl[r].code));
            chk($sformatf("row%0d onehot", r), int'(onehot_out), int'(tbl[r].oh));
            chk($sformatf("row%0d frame_err", r), int'(frame_err), int'(tbl[r].ferr));
            chk($sformatf("row%0d rx_count", r), int'(rx_count), int'(tbl[r].cnt));
        end
        err_clr = 1'b0;

        // Random segments: each is a word held for 1..7 cycles, distinct from its neighbour.
        // A segment loses its first sample when the link was mid-qualification or in a bad
        // word, because that sample only ends the previous episode.
        lost = 0; prev = -1; mlast = 8'h00;
        while (d.size() < 1500) begin
            case ($urandom_range(0, 9))
                0, 1:    w = 8'h00;
                2:       w = (8'($urandom_range(1, 31)) << 3) | 8'($urandom_range(0, 7));
                default: w = 8'($urandom_range(1, 7));
            endcase
            if (int'(w) == prev) continue;
            prev = int'(w);
            len  = $urandom_range(1, 7);
            s    = d.size();
            for (int k = 0; k < len; k++) begin
                d.push_back(w); evv.push_back(1'b0); evb.push_back(1'b0);
            end
            if (len <= lost) begin
                lost = 0;
            end else begin
                f = s + lost;
                if (w == mlast) begin
                    lost = 0;
                end else if (w > 8'h07) begin
                    evb[f] = 1'b1; lost = 1;
                end else if (w == 8'h00) begin
                    mlast = 8'h00; lost = 0;
                end else if (len - lost >= SC) begin
                    evv[f + SC - 1] = 1'b1; mlast = w; lost = 0;
                end else begin
                    lost = 1;
                end
            end
        end

        rst = 1'b0; data_in = 8'h00;
        repeat (2) tick();
        rst = 1'b1;
        mcode = 3'd0; mcnt = 8'd0; mferr = 1'b0;
        for (int i = 0; i < d.size(); i++) begin
            data_in = d[i];
            tick();
            if (i > 0) begin
                if (evv[i-1]) begin
                    mcode = d[i-1][2:0];
                    if (mcnt != 8'hFF) mcnt = mcnt + 8'd1;
                end
                if (evb[i-1]) mferr = 1'b1;
                chk($sformatf("rnd%0d valid", i), int'(code_valid), int'(evv[i-1]));
                chk($sformatf("rnd%0d code_out", i), int'(code_out), int'(mcode));
                chk($sformatf("rnd%0d onehot", i), int'(onehot_out), (mcnt == 0) ? 0 : (1 << mcode));
                chk($sformatf("rnd%0d frame_err", i), int'(frame_err), int'(mferr));
                chk($sformatf("rnd%0d rx_count", i), int'(rx_count), int'(mcnt));
            end
        end

        // Narrow counter saturates while strobes keep coming.
        codes2 = '{1, 2, 1, 2, 1};
        repeat (2) @(posedge clk);
        #1 rst2 = 1'b1;
        pulses = 0;
        foreach (codes2[c]) begin
            data2 = 8'(codes2[c]);
            for (int k = 0; k < 8; k++) begin
                tick();
                if (code_valid2) pulses++;
            end
            chk($sformatf("sat step%0d rx_count", c), int'(rx_count2), (c + 1 > 3) ? 3 : c + 1);
        end
        chk("sat pulses", pulses, 5);
        chk("sat rx_count", int'(rx_count2), 3);
        chk("sat code_out", int'(code_out2), 1);
        chk("sat onehot", int'(onehot_out2), 8'h02);
        chk("sat frame_err", int'(frame_err2), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
